pc_gen: RTL and testbench

- Parametrised successor to the fetch-stage PC register.
- Generates the instruction-fetch address (pc) and the instruction-memory chip enable (ce).
- Supports configurable address width, reset vector and increment; pipeline stall; branch redirect; exception flush; and an instruction-memory ready handshake.
- Sits at the head of the pipeline, driving the IF/ID stage and the instruction ROM. Takes stall from the control unit, branch from ID, and flush/new_pc from the exception controller.

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_next_sel.sv | 68 ++++++
 rtl/pc_gen.sv | 108 ++++++++++
 tb/tb_pc_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared constants for the fetch-stage PC generator: FSM encodings, reset/enable levels, default vector.
package pc_gen_pkg;

  localparam logic [1:0] PCG_IDLE = 2'd0;
  localparam logic [1:0] PCG_BOOT = 2'd1;
  localparam logic [1:0] PCG_RUN  = 2'd2;
  localparam logic [1:0] PCG_WAIT = 2'd3;

  localparam logic RstAssert   = 1'b0;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic [31:0] PCG_DEF_RESET_VEC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: flush > hold > branch > pending > sequential increment.
// Optional PC_ALIGN_CHECK_EN forces redirect targets onto an INC boundary and flags the fix-up.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INC    = 4
) (
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pend_valid_i,
  input  logic [ADDR_W-1:0] pend_target_i,
  output logic [ADDR_W-1:0] pc_next_o,
  output logic              pend_valid_o,
  output logic [ADDR_W-1:0] pend_target_o,
  output logic              misalign_o
);

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] target_fixed;
  logic [ADDR_W-1:0] seq_pc;

  always_comb begin
    redirect      = 1'b0;
    target        = '0;
    seq_pc        = pc_i + ADDR_W'(INC);
    pend_valid_o  = pend_valid_i;
    pend_target_o = pend_target_i;
    if (flush_i) begin
      redirect     = 1'b1;
      target       = new_pc_i;
      pend_valid_o = 1'b0;
    end else if (hold_i) begin
      // A branch seen while held is parked; a later one overwrites it.
      seq_pc = pc_i;
      if (branch_i) begin
        pend_valid_o  = 1'b1;
        pend_target_o = branch_target_i;
      end
    end else if (branch_i) begin
      redirect     = 1'b1;
      target       = branch_target_i;
      pend_valid_o = 1'b0;
    end else if (pend_valid_i) begin
      redirect     = 1'b1;
      target       = pend_target_i;
      pend_valid_o = 1'b0;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam int                LOW_BITS = $clog2(INC);
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << LOW_BITS) - 1);
  assign misalign_o   = redirect && ((target & LOW_MASK) != '0);
  assign target_fixed = target & ~LOW_MASK;
`else
  assign misalign_o   = 1'b0;
  assign target_fixed = target;
`endif

  assign pc_next_o = redirect ? target_fixed : seq_pc;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: IDLE/BOOT/RUN/WAIT sequencing, branch-pending slot, imem handshake.
// Optional alignment fix-up and misalign flag are enabled with the PC_ALIGN_CHECK_EN macro.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(PCG_DEF_RESET_VEC),
  parameter int                INC       = 4,
  parameter int                STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               imem_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               pc_valid,
  output logic               misalign,
  output logic [1:0]         state_o
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ce_q, ce_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              misalign_q, misalign_d;

  logic [ADDR_W-1:0] sel_pc;
  logic              sel_pend_valid;
  logic [ADDR_W-1:0] sel_pend_target;
  logic              sel_misalign;
  logic              unused_stall;

  // Handshake: the address on pc is accepted by instruction memory on any edge where
  // imem_ready is high; without acceptance pc holds (as for a stall) and the FSM sits in WAIT.
  pc_next_sel #(
    .ADDR_W (ADDR_W),
    .INC    (INC)
  ) u_next_sel (
    .flush_i         (flush),
    .hold_i          (stall[0] | ~imem_ready),
    .branch_i        (branch_flag),
    .branch_target_i (branch_target),
    .new_pc_i        (new_pc),
    .pc_i            (pc_q),
    .pend_valid_i    (pend_valid_q),
    .pend_target_i   (pend_target_q),
    .pc_next_o       (sel_pc),
    .pend_valid_o    (sel_pend_valid),
    .pend_target_o   (sel_pend_target),
    .misalign_o      (sel_misalign)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    ce_d          = ce_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    misalign_d    = 1'b0;
    case (state_q)
      PCG_IDLE: begin
        state_d = PCG_BOOT;
        ce_d    = ChipEnable;
        pc_d    = RESET_VEC;
      end
      PCG_BOOT: state_d = PCG_RUN;
      default: begin
        pc_d          = sel_pc;
        pend_valid_d  = sel_pend_valid;
        pend_target_d = sel_pend_target;
        misalign_d    = sel_misalign;
        state_d       = (flush || imem_ready) ? PCG_RUN : PCG_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstAssert) begin
      state_q       <= PCG_IDLE;
      pc_q          <= RESET_VEC;
      ce_q          <= ChipDisable;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ce_q          <= ce_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      misalign_q    <= misalign_d;
    end
  end

  assign unused_stall = ^stall;
  assign pc           = pc_q;
  assign ce           = ce_q;
  assign pc_valid     = ce_q && (state_q == PCG_RUN);
  assign misalign     = misalign_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: a 32-bit instance (RESET_VEC 0x100) and an 8-bit wrap instance.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam int EW = 38;  // {sel8, pc[31:0], state[1:0], ce, pc_valid, misalign}

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        flush;
  logic [31:0] new_pc;
  logic        imem_ready;
  logic [31:0] pc;
  logic        ce, pc_valid, misalign;
  logic [1:0]  state;

  logic        rst8;
  logic [5:0]  stall8;
  logic        branch_flag8, flush8, imem_ready8;
  logic [7:0]  branch_target8, new_pc8;
  logic [7:0]  pc8;
  logic        ce8, pc_valid8, misalign8;
  logic [1:0]  state8;

  logic [EW-1:0] exp_q[$];
  int n_vec;
  int n_err;

  pc_gen #(.ADDR_W(32), .RESET_VEC(32'h0000_0100), .INC(4), .STALL_W(6)) u_dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_flag(branch_flag),
    .branch_target(branch_target), .flush(flush), .new_pc(new_pc),
    .imem_ready(imem_ready), .pc(pc), .ce(ce), .pc_valid(pc_valid),
    .misalign(misalign), .state_o(state)
  );

  pc_gen #(.ADDR_W(8), .RESET_VEC(8'hF4), .INC(4), .STALL_W(6)) u_dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .branch_flag(branch_flag8),
    .branch_target(branch_target8), .flush(flush8), .new_pc(new_pc8),
    .imem_ready(imem_ready8), .pc(pc8), .ce(ce8), .pc_valid(pc_valid8),
    .misalign(misalign8), .state_o(state8)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] pack_exp(input logic sel, input logic [31:0] e_pc,
                                             input logic [1:0] e_st, input logic e_mis);
    pack_exp = {sel, e_pc, e_st, (e_st != PCG_IDLE), (e_st == PCG_RUN), e_mis};
  endfunction

  function automatic logic [EW-1:0] pack_act(input logic sel);
    if (sel) pack_act = {1'b1, 24'h0, pc8, state8, ce8, pc_valid8, misalign8};
    else     pack_act = {1'b0, pc, state, ce, pc_valid, misalign};
  endfunction

  task automatic compare(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got pc=%h st=%0d ce=%b pv=%b mis=%b, expected pc=%h st=%0d ce=%b pv=%b mis=%b",
               name, act[36:5], act[4:3], act[2], act[1], act[0],
               exp[36:5], exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // driver tasks: inputs change on the falling edge, expectation is for after the next rising edge
  task automatic drive(input logic s0, input logic bf, input logic [31:0] bt,
                       input logic fl, input logic [31:0] np, input logic rdy,
                       input logic [31:0] e_pc, input logic [1:0] e_st, input logic e_mis);
    @(negedge clk);
    rst           = 1'b1;
    stall         = {5'b0, s0};
    branch_flag   = bf;
    branch_target = bt;
    flush         = fl;
    new_pc        = np;
    imem_ready    = rdy;
    exp_q.push_back(pack_exp(1'b0, e_pc, e_st, e_mis));
  endtask

  task automatic drive8(input logic [7:0] e_pc, input logic [1:0] e_st);
    @(negedge clk);
    rst8 = 1'b1;
    exp_q.push_back(pack_exp(1'b1, {24'h0, e_pc}, e_st, 1'b0));
  endtask

  // scoreboard monitor
  initial begin
    logic [EW-1:0] e;
    int idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        compare($sformatf("vec%0d", idx), pack_act(e[EW-1]), e);
        idx++;
      end
    end
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; rst8 = 1'b1;
    stall = '0; branch_flag = 1'b0; branch_target = '0; flush = 1'b0; new_pc = '0; imem_ready = 1'b1;
    stall8 = '0; branch_flag8 = 1'b0; branch_target8 = '0; flush8 = 1'b0; new_pc8 = '0; imem_ready8 = 1'b1;
    #1;
    rst = 1'b0; rst8 = 1'b0;
    #1;
    compare("reset32", pack_act(1'b0), pack_exp(1'b0, 32'h100, PCG_IDLE, 1'b0));
    compare("reset8", pack_act(1'b1), pack_exp(1'b1, 32'hF4, PCG_IDLE, 1'b0));

    // boot and sequential fetch
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h100,  PCG_BOOT, 0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h100,  PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h104,  PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h108,  PCG_RUN,  0);
    // branch
    drive(0, 1, 32'h2000, 0, 32'h0,   1, 32'h2000, PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h2004, PCG_RUN,  0);
    // stalled branch becomes pending
    drive(1, 1, 32'h3000, 0, 32'h0,   1, 32'h2004, PCG_RUN,  0);
    drive(1, 0, 32'h0,    0, 32'h0,   1, 32'h2004, PCG_RUN,  0);
    drive(1, 0, 32'h0,    0, 32'h0,   1, 32'h2004, PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h3000, PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h3004, PCG_RUN,  0);
    // memory not ready, then flush out of WAIT
    drive(0, 0, 32'h0,    0, 32'h0,   0, 32'h3004, PCG_WAIT, 0);
    drive(0, 0, 32'h0,    0, 32'h0,   0, 32'h3004, PCG_WAIT, 0);
    drive(0, 0, 32'h0,    1, 32'h80,  0, 32'h80,   PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h84,   PCG_RUN,  0);
    // misaligned branch target
`ifdef PC_ALIGN_CHECK_EN
    drive(0, 1, 32'h2002, 0, 32'h0,   1, 32'h2000, PCG_RUN,  1);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h2004, PCG_RUN,  0);
`else
    drive(0, 1, 32'h2002, 0, 32'h0,   1, 32'h2002, PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h2006, PCG_RUN,  0);
`endif
    // flush beats stall and branch; branch is not parked
    drive(1, 1, 32'h5000, 1, 32'h400, 1, 32'h400,  PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h404,  PCG_RUN,  0);
    // latest stalled branch wins
    drive(1, 1, 32'h6000, 0, 32'h0,   1, 32'h404,  PCG_RUN,  0);
    drive(1, 1, 32'h7000, 0, 32'h0,   1, 32'h404,  PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h7000, PCG_RUN,  0);
    drive(0, 0, 32'h0,    1, 32'h900, 1, 32'h900,  PCG_RUN,  0);
    // flush discards a pending branch
    drive(1, 1, 32'hA000, 0, 32'h0,   1, 32'h900,  PCG_RUN,  0);
    drive(0, 0, 32'h0,    1, 32'hB00, 1, 32'hB00,  PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'hB04,  PCG_RUN,  0);
    // WAIT released by ready advances pc
    drive(0, 0, 32'h0,    0, 32'h0,   0, 32'hB04,  PCG_WAIT, 0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'hB08,  PCG_RUN,  0);

    // asynchronous reset mid-run, checked without a clock edge
    @(negedge clk);
    rst = 1'b0;
    #1;
    compare("async_reset", pack_act(1'b0), pack_exp(1'b0, 32'h100, PCG_IDLE, 1'b0));
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h100,  PCG_BOOT, 0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h100,  PCG_RUN,  0);
    drive(0, 0, 32'h0,    0, 32'h0,   1, 32'h104,  PCG_RUN,  0);

    // 8-bit instance: silent wrap past 0xFC
    drive8(8'hF4, PCG_BOOT);
    drive8(8'hF4, PCG_RUN);
    drive8(8'hF8, PCG_RUN);
    drive8(8'hFC, PCG_RUN);
    drive8(8'h00, PCG_RUN);
    drive8(8'h04, PCG_RUN);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
